// File: rtl/pc_predict_unit.sv
// Registered fetch PC with a direct-mapped BTB of 2-bit saturating counters.
// Execute-stage resolutions train the BTB; mispredicts and CSR redirects steer the PC and flush.
module pc_predict_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_8000,
  parameter int              BTB_IDX_W    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            csr_redirect,
  input  logic [XLEN-1:0] csr_pc,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            flush
);

  localparam int ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W   = XLEN - BTB_IDX_W - 2;

  logic [XLEN-1:0]      pc_q;
  logic [XLEN-1:0]      pc_next;

  logic                 btb_valid  [ENTRIES];
  logic [TAG_W-1:0]     btb_tag    [ENTRIES];
  logic [XLEN-1:0]      btb_target [ENTRIES];
  logic [1:0]           btb_ctr    [ENTRIES];

  logic [BTB_IDX_W-1:0] look_idx;
  logic [TAG_W-1:0]     look_tag;
  logic                 look_hit;

  logic                 taken_eff;
  logic                 mispredict;

  logic                 upd_en;
  logic [BTB_IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0]     upd_tag;
  logic                 upd_train;
  logic [1:0]           upd_ctr_old;
  logic [1:0]           upd_ctr_new;

  // Lookup always reads the registered array, so a same-cycle update is not bypassed.
  assign look_idx    = pc_q[BTB_IDX_W+1:2];
  assign look_tag    = pc_q[XLEN-1:BTB_IDX_W+2];
  assign look_hit    = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign pred_taken  = look_hit && btb_ctr[look_idx][1];
  assign pred_target = btb_target[look_idx];

  assign taken_eff   = ex_is_jump | ex_taken;
  assign mispredict  = ex_valid &&
                       ((taken_eff != ex_pred_taken) ||
                        (taken_eff && (ex_target != ex_pred_target)));
  assign flush       = rst_n & (csr_redirect | mispredict);

  always_comb begin
    pc_next = pc_plus4;
    if (csr_redirect) begin
      pc_next = csr_pc;
    end else if (mispredict) begin
      pc_next = taken_eff ? ex_target : (ex_pc + XLEN'(4));
    end else if (stall) begin
      pc_next = pc_q;
    end else if (pred_taken) begin
      pc_next = pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_next;
    end
  end

  // Training path: an invalid entry or a tag match trains in place; a valid
  // entry owned by another tag is only stolen by a taken resolution.
  assign upd_en      = ex_valid && (ex_is_branch || ex_is_jump);
  assign upd_idx     = ex_pc[BTB_IDX_W+1:2];
  assign upd_tag     = ex_pc[XLEN-1:BTB_IDX_W+2];
  assign upd_train   = !btb_valid[upd_idx] || (btb_tag[upd_idx] == upd_tag);
  assign upd_ctr_old = btb_ctr[upd_idx];

  always_comb begin
    upd_ctr_new = upd_ctr_old;
    if (taken_eff) begin
      if (upd_ctr_old != 2'b11) upd_ctr_new = upd_ctr_old + 2'b01;
    end else begin
      if (upd_ctr_old != 2'b00) upd_ctr_new = upd_ctr_old - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b01;
      end
    end else if (upd_en) begin
      if (upd_train) begin
        btb_ctr[upd_idx] <= upd_ctr_new;
        if (taken_eff) begin
          btb_valid[upd_idx]  <= 1'b1;
          btb_tag[upd_idx]    <= upd_tag;
          btb_target[upd_idx] <= ex_target;
        end
      end else if (taken_eff) begin
        btb_valid[upd_idx]  <= 1'b1;
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= ex_target;
        btb_ctr[upd_idx]    <= ex_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

endmodule
